store_buffer_fwd: RTL

Parametrised store buffer between the LSU/MMU and the data cache. It is a circular FIFO of committed stores with valid/ready handshakes on both sides and occupancy-based full/empty, so all DEPTH entries are usable. It adds a combinational store-to-load forwarding port: the LSU probes it with a load address and byte mask and gets forwarded data, a miss, or a stall request. Drained entries go to the dcache in program order.

---
 rtl/store_buffer_fwd_if.sv | 33 +++
 rtl/store_buffer_fwd.sv | 133 +++++++++++++
 2 files changed

// File: rtl/store_buffer_fwd_if.sv
// Store-side and drain-side handshake bundle of the store buffer.
// The master modport is the LSU/dcache side; the slave modport is the buffer itself.
interface store_buffer_fwd_if #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8
);
    logic                      lsummu2stb_valid;
    logic                      lsummu2stb_ready;
    logic [ADDR_WIDTH-1:0]     lsummu2stb_addr;
    logic [DATA_WIDTH-1:0]     lsummu2stb_wdata;
    logic [BYTE_SEL_WIDTH-1:0] lsummu2stb_sel_byte;

    logic                      stb2dcache_valid;
    logic                      dcache2stb_ready;
    logic [ADDR_WIDTH-1:0]     stb2dcache_addr;
    logic [DATA_WIDTH-1:0]     stb2dcache_wdata;
    logic [BYTE_SEL_WIDTH-1:0] stb2dcache_sel_byte;

    modport master (
        output lsummu2stb_valid, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
        output dcache2stb_ready,
        input  lsummu2stb_ready,
        input  stb2dcache_valid, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte
    );

    modport slave (
        input  lsummu2stb_valid, lsummu2stb_addr, lsummu2stb_wdata, lsummu2stb_sel_byte,
        input  dcache2stb_ready,
        output lsummu2stb_ready,
        output stb2dcache_valid, stb2dcache_addr, stb2dcache_wdata, stb2dcache_sel_byte
    );
endinterface

// File: rtl/store_buffer_fwd.sv
// Circular store buffer draining committed stores to the dcache in order, with a
// combinational store-to-load forwarding lookup (hit / miss / stall on partial overlap).
module store_buffer_fwd #(
    parameter int DEPTH          = 8,
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int BYTE_SEL_WIDTH = DATA_WIDTH / 8,
    parameter int CNT_WIDTH      = $clog2(DEPTH) + 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    store_buffer_fwd_if.slave         stb_if,
    input  logic                      ld_req,
    input  logic [ADDR_WIDTH-1:0]     ld_addr,
    input  logic [BYTE_SEL_WIDTH-1:0] ld_sel_byte,
    output logic                      ld_fwd_hit,
    output logic [DATA_WIDTH-1:0]     ld_fwd_data,
    output logic                      ld_stall,
    output logic                      stb_full,
    output logic                      stb_empty,
    output logic [CNT_WIDTH-1:0]      stb_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BYTE_SEL_WIDTH);
    localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'((1 << OFF_W) - 1);

    logic [ADDR_WIDTH-1:0]     entry_addr_q [DEPTH];
    logic [DATA_WIDTH-1:0]     entry_data_q [DEPTH];
    logic [BYTE_SEL_WIDTH-1:0] entry_sel_q  [DEPTH];

    logic [DEPTH-1:0]     valid_q, valid_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    logic push, pop;

    assign stb_full  = (count_q == CNT_WIDTH'(DEPTH));
    assign stb_empty = (count_q == '0);
    assign stb_count = count_q;

    assign push = stb_if.lsummu2stb_valid && !stb_full;
    assign pop  = stb_if.dcache2stb_ready && !stb_empty;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        valid_d  = valid_q;
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the payload array has no reset; valid bits and the empty gate keep it unobservable.
    always_ff @(posedge clk) begin
        if (push) begin
            entry_addr_q[wr_ptr_q] <= stb_if.lsummu2stb_addr;
            entry_data_q[wr_ptr_q] <= stb_if.lsummu2stb_wdata;
            entry_sel_q[wr_ptr_q]  <= stb_if.lsummu2stb_sel_byte;
        end
    end

    assign stb_if.lsummu2stb_ready    = !stb_full;
    assign stb_if.stb2dcache_valid    = !stb_empty;
    assign stb_if.stb2dcache_addr     = stb_empty ? '0 : entry_addr_q[rd_ptr_q];
    assign stb_if.stb2dcache_wdata    = stb_empty ? '0 : entry_data_q[rd_ptr_q];
    assign stb_if.stb2dcache_sel_byte = stb_empty ? '0 : entry_sel_q[rd_ptr_q];

    logic [PTR_W-1:0]          scan_idx;
    logic                      match_any;
    logic [BYTE_SEL_WIDTH-1:0] match_sel;
    logic [DATA_WIDTH-1:0]     match_data;
    logic [DATA_WIDTH-1:0]     lane_mask;
    logic                      full_cover;

    // Walk oldest to youngest from the head so the last match seen is the youngest.
    always_comb begin
        scan_idx   = rd_ptr_q;
        match_any  = 1'b0;
        match_sel  = '0;
        match_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
            scan_idx = rd_ptr_q + PTR_W'(k);
            if (valid_q[scan_idx]
                && (((entry_addr_q[scan_idx] ^ ld_addr) & WORD_MASK) == '0)
                && ((entry_sel_q[scan_idx] & ld_sel_byte) != '0)) begin
                match_any  = 1'b1;
                match_sel  = entry_sel_q[scan_idx];
                match_data = entry_data_q[scan_idx];
            end
        end
    end

    always_comb begin
        lane_mask = '0;
        for (int b = 0; b < BYTE_SEL_WIDTH; b++) begin
            lane_mask[8*b +: 8] = {8{ld_sel_byte[b]}};
        end
    end

    assign full_cover  = ((match_sel & ld_sel_byte) == ld_sel_byte);
    assign ld_fwd_hit  = ld_req && match_any && full_cover;
    assign ld_stall    = ld_req && match_any && !full_cover;
    assign ld_fwd_data = ld_fwd_hit ? (match_data & lane_mask) : '0;

endmodule
